// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mux_pkg
//  Brief   : Shared constants and helpers for the N:1 stream multiplexer.
//  Revision: 1.0
// ============================================================================
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // An index needs at least one bit, even for a single channel.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : rr_arbiter
//  Brief   : Combinational round-robin pick: first request after ptr, wrapping.
//  Revision: 1.0
// ============================================================================
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = clog2_min1(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  grant,
    output logic              grant_ok
);

    // Walk from the farthest offset down so the nearest request wins.
    always_comb begin
        grant    = '0;
        grant_ok = |req;
        for (int k = NUM_CH; k >= 1; k--) begin
            logic [SEL_W-1:0] idx;
            idx = SEL_W'((int'(ptr) + k) % NUM_CH);
            if (req[idx]) begin
                grant = idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_nch_stream.sv
`default_nettype none
// ============================================================================
//  Module  : mux_nch_stream
//  Brief   : N:1 valid/ready stream mux, select or round-robin, registered out.
//  Revision: 1.0
// ============================================================================
module mux_nch_stream
    import mux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = clog2_min1(NUM_CH)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     mode_in,
    input  logic [SEL_W-1:0]         sel_in,
    input  logic [NUM_CH-1:0]        in_valid_in,
    input  logic [NUM_CH*DATA_W-1:0] in_data_in,
    output logic [NUM_CH-1:0]        in_ready_out,
    output logic                     out_valid_out,
    output logic [DATA_W-1:0]        out_data_out,
    output logic [SEL_W-1:0]         out_ch_out,
    input  logic                     out_ready_in
);

    logic              load_en;
    logic              sel_ok;
    logic              rr_ok;
    logic              grant_ok;
    logic              xfer;
    logic [SEL_W-1:0]  rr_grant;
    logic [SEL_W-1:0]  grant;
    logic [SEL_W-1:0]  rr_ptr;
    logic [DATA_W-1:0] grant_data;

    assign load_en = !out_valid_out || out_ready_in;
    assign sel_ok  = (int'(sel_in) < NUM_CH);

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_rr_arbiter (
        .req      (in_valid_in),
        .ptr      (rr_ptr),
        .grant    (rr_grant),
        .grant_ok (rr_ok)
    );

    always_comb begin
        grant    = sel_in;
        grant_ok = sel_ok;
        if (mode_in == MODE_RR) begin
            grant    = rr_grant;
            grant_ok = rr_ok;
        end
    end

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ready
            // Gated by reset so no producer sees ready while the block is held.
            assign in_ready_out[i] = !rst_in && load_en && grant_ok &&
                                     (grant == SEL_W'(i));
        end
    endgenerate

    assign xfer = |(in_valid_in & in_ready_out);

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data = in_data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            out_valid_out <= 1'b0;
            out_data_out  <= '0;
            out_ch_out    <= '0;
            rr_ptr        <= SEL_W'(NUM_CH - 1);
        end else if (xfer) begin
            out_valid_out <= 1'b1;
            out_data_out  <= grant_data;
            out_ch_out    <= grant;
            rr_ptr        <= grant;
        end else if (load_en) begin
            out_valid_out <= 1'b0;
        end
    end

endmodule
`default_nettype wire
